// File: rtl/prio_arbiter_pkg.sv
// Shared definitions for the prio_arbiter block.
//   ARB_MODE_FIXED / ARB_MODE_RR : values for the ROUND_ROBIN parameter.
//   arb_state_e                  : arbiter state encoding (idle / holding a grant).
package prio_arbiter_pkg;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

endpackage

// File: rtl/prio_arbiter_encoder.sv
// Priority encoder: reports the index of the highest set input bit.
//   i_in  : 2**OUT_WIDTH candidate bits
//   o_idx : index of the highest set bit, 0 when i_in is all zero
//   o_any : OR of i_in (validity never inferred from o_idx)
module Encoder #(
  parameter int unsigned OUT_WIDTH = 3
) (
  input  logic [(1 << OUT_WIDTH)-1:0] i_in,
  output logic [OUT_WIDTH-1:0]        o_idx,
  output logic                        o_any
);

  localparam int unsigned N = 1 << OUT_WIDTH;

  // Ascending scan: the last set bit seen (the highest) wins.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_in[i]) begin
        o_idx = OUT_WIDTH'(i);
      end
    end
  end

  assign o_any = |i_in;

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way request arbiter (fixed priority or round-robin) with optional
// hold-time preemption.
//   i_clk         : clock, all state changes on the rising edge
//   i_rst_n       : synchronous active-low reset
//   i_req         : level request vector, bit i is requester i
//   o_grant_valid : a grant is held
//   o_grant_idx   : holder index, 0 when idle
//   o_grant_oh    : holder one-hot, 0 when idle
//   o_switched    : pulse in the first cycle of every new grant
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int unsigned IDX_WIDTH   = 3,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned MAX_HOLD    = 0,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [(1 << IDX_WIDTH)-1:0]  i_req,
  output logic                         o_grant_valid,
  output logic [IDX_WIDTH-1:0]         o_grant_idx,
  output logic [(1 << IDX_WIDTH)-1:0]  o_grant_oh,
  output logic                         o_switched
);

  localparam int unsigned N    = 1 << IDX_WIDTH;
  localparam bit          IsRr = (ROUND_ROBIN == ARB_MODE_RR);
  localparam logic [CNT_WIDTH-1:0] MaxHold = CNT_WIDTH'(MAX_HOLD);
  // With unlimited hold the counter only needs to stop somewhere; park it at all-ones.
  localparam logic [CNT_WIDTH-1:0] CntSat  = (MAX_HOLD != 0) ? MaxHold : {CNT_WIDTH{1'b1}};

  arb_state_e             r_state, w_state_d;
  logic [IDX_WIDTH-1:0]   r_idx, w_idx_d;
  logic [N-1:0]           r_oh, w_oh_d;
  logic                   r_sw, w_sw_d;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_d;
  logic [IDX_WIDTH-1:0]   r_last, w_last_d;

  logic                   w_holder_req;
  logic [N-1:0]           w_others;
  logic                   w_preempt;
  logic [N-1:0]           w_cand;
  logic [N-1:0]           w_mask;
  logic [IDX_WIDTH-1:0]   w_m_idx, w_u_idx, w_win;
  logic                   w_m_any, w_u_any;

  assign w_holder_req = |(i_req & r_oh);
  assign w_others     = i_req & ~r_oh;
  // A lone holder is never preempted: a competitor must be pending.
  assign w_preempt    = (MAX_HOLD != 0) && w_holder_req && (r_cnt >= MaxHold) && (|w_others);
  assign w_cand       = w_preempt ? w_others : i_req;

  // Bits strictly below the last winner get first pick in round-robin mode.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (IDX_WIDTH'(i) < r_last);
    end
  end

  Encoder #(
    .OUT_WIDTH (IDX_WIDTH)
  ) u_enc_masked (
    .i_in  (w_cand & w_mask),
    .o_idx (w_m_idx),
    .o_any (w_m_any)
  );

  Encoder #(
    .OUT_WIDTH (IDX_WIDTH)
  ) u_enc_full (
    .i_in  (w_cand),
    .o_idx (w_u_idx),
    .o_any (w_u_any)
  );

  assign w_win = (IsRr && w_m_any) ? w_m_idx : w_u_idx;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_oh_d    = r_oh;
    w_sw_d    = 1'b0;
    w_cnt_d   = r_cnt;
    w_last_d  = r_last;
    if (r_state == StBusy && w_holder_req && !w_preempt) begin
      if (r_cnt != CntSat) begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end else if (w_u_any) begin
      // New grant: from idle, after preemption, or holder released.
      w_state_d = StBusy;
      w_idx_d   = w_win;
      w_oh_d    = N'(1) << w_win;
      w_sw_d    = 1'b1;
      w_cnt_d   = CNT_WIDTH'(1);
      if (IsRr) begin
        w_last_d = w_win;
      end
    end else begin
      w_state_d = StIdle;
      w_idx_d   = '0;
      w_oh_d    = '0;
      w_cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_oh    <= '0;
      r_sw    <= 1'b0;
      r_cnt   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_oh    <= w_oh_d;
      r_sw    <= w_sw_d;
      r_cnt   <= w_cnt_d;
      r_last  <= w_last_d;
    end
  end

  assign o_grant_valid = (r_state == StBusy);
  assign o_grant_idx   = r_idx;
  assign o_grant_oh    = r_oh;
  assign o_switched    = r_sw;

endmodule
